result_bus_arbiter: RTL and testbench

RESULT_BUS_ARBITER -- requirements
Module: result_bus_arbiter

---
 rtl/result_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_result_bus_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/result_bus_arbiter.sv
// result_bus_arbiter: two-requester arbiter (ALU reservation stations "rss"
// and load/store buffer "lsb") onto a shared, registered result bus.
//
// Each requester owns one pending slot. A slot is filled when its request is
// present (dest != 0) and ready_to_x is high. Every enabled cycle, at most one
// valid slot is granted and copied into the output registers, which are
// zeroed after any cycle with no grant. Each broadcast is therefore visible
// for exactly one cycle.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   rdy                  global enable; everything freezes while low
//   reset_from_rob_bus   misprediction flush, same effect as rst
//   dest/value/next_pc_from_rss, ready_to_rss   ALU result request
//   dest/value_from_lsb, ready_to_lsb           load result request
//   dest/value/next_pc/src_to_bus               registered bus outputs
//                                               (src 0 = rss, 1 = lsb)
//
// Configuration macro: RESULT_BUS_ARB_FIXED_PRIO_EN
//   defined   -> lsb always wins when both slots are valid (no pointer)
//   undefined -> round-robin using a 1-bit priority pointer
module result_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        reset_from_rob_bus,
  input  logic [4:0]  dest_from_rss,
  input  logic [31:0] value_from_rss,
  input  logic [31:0] next_pc_from_rss,
  output logic        ready_to_rss,
  input  logic [4:0]  dest_from_lsb,
  input  logic [31:0] value_from_lsb,
  output logic        ready_to_lsb,
  output logic [4:0]  dest_to_bus,
  output logic [31:0] value_to_bus,
  output logic [31:0] next_pc_to_bus,
  output logic        src_to_bus
);

  logic        rss_v_q, rss_v_d;
  logic [4:0]  rss_dest_q, rss_dest_d;
  logic [31:0] rss_val_q, rss_val_d;
  logic [31:0] rss_pc_q, rss_pc_d;
  logic        lsb_v_q, lsb_v_d;
  logic [4:0]  lsb_dest_q, lsb_dest_d;
  logic [31:0] lsb_val_q, lsb_val_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] val_q, val_d;
  logic [31:0] pc_q, pc_d;
  logic        src_q, src_d;
  logic        grant_rss, grant_lsb;
  logic        acc_rss, acc_lsb;
`ifndef RESULT_BUS_ARB_FIXED_PRIO_EN
  logic        ptr_q, ptr_d;
`endif

  // Grant decision from registered slot state only
  always_comb begin
`ifdef RESULT_BUS_ARB_FIXED_PRIO_EN
    grant_lsb = lsb_v_q;
    grant_rss = rss_v_q && !lsb_v_q;
`else
    grant_rss = rss_v_q && (!lsb_v_q || !ptr_q);
    grant_lsb = lsb_v_q && (!rss_v_q || ptr_q);
`endif
  end

  // A slot can take a new request if it is empty or drains this cycle
  assign ready_to_rss = !rst && rdy && !reset_from_rob_bus && (!rss_v_q || grant_rss);
  assign ready_to_lsb = !rst && rdy && !reset_from_rob_bus && (!lsb_v_q || grant_lsb);
  assign acc_rss      = ready_to_rss && (dest_from_rss != 5'd0);
  assign acc_lsb      = ready_to_lsb && (dest_from_lsb != 5'd0);

  // Next-state: slots, pointer and bus registers (all hold while rdy is low)
  always_comb begin
    rss_v_d    = rss_v_q;
    rss_dest_d = rss_dest_q;
    rss_val_d  = rss_val_q;
    rss_pc_d   = rss_pc_q;
    lsb_v_d    = lsb_v_q;
    lsb_dest_d = lsb_dest_q;
    lsb_val_d  = lsb_val_q;
    dest_d     = dest_q;
    val_d      = val_q;
    pc_d       = pc_q;
    src_d      = src_q;
`ifndef RESULT_BUS_ARB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    if (rdy) begin
      dest_d = 5'd0;
      val_d  = 32'd0;
      pc_d   = 32'd0;
      src_d  = 1'b0;
      if (grant_rss) begin
        dest_d  = rss_dest_q;
        val_d   = rss_val_q;
        pc_d    = rss_pc_q;
        rss_v_d = 1'b0;
      end else if (grant_lsb) begin
        dest_d  = lsb_dest_q;
        val_d   = lsb_val_q;
        src_d   = 1'b1;
        lsb_v_d = 1'b0;
      end
`ifndef RESULT_BUS_ARB_FIXED_PRIO_EN
      // Contention hands priority to the loser
      if (rss_v_q && lsb_v_q) ptr_d = !ptr_q;
`endif
      // A refill on the grant edge overrides the clear
      if (acc_rss) begin
        rss_v_d    = 1'b1;
        rss_dest_d = dest_from_rss;
        rss_val_d  = value_from_rss;
        rss_pc_d   = next_pc_from_rss;
      end
      if (acc_lsb) begin
        lsb_v_d    = 1'b1;
        lsb_dest_d = dest_from_lsb;
        lsb_val_d  = value_from_lsb;
      end
    end
  end

  // State registers; reset and flush discard everything
  always_ff @(posedge clk) begin
    if (rst || reset_from_rob_bus) begin
      rss_v_q    <= 1'b0;
      rss_dest_q <= 5'd0;
      rss_val_q  <= 32'd0;
      rss_pc_q   <= 32'd0;
      lsb_v_q    <= 1'b0;
      lsb_dest_q <= 5'd0;
      lsb_val_q  <= 32'd0;
      dest_q     <= 5'd0;
      val_q      <= 32'd0;
      pc_q       <= 32'd0;
      src_q      <= 1'b0;
`ifndef RESULT_BUS_ARB_FIXED_PRIO_EN
      ptr_q      <= 1'b0;
`endif
    end else begin
      rss_v_q    <= rss_v_d;
      rss_dest_q <= rss_dest_d;
      rss_val_q  <= rss_val_d;
      rss_pc_q   <= rss_pc_d;
      lsb_v_q    <= lsb_v_d;
      lsb_dest_q <= lsb_dest_d;
      lsb_val_q  <= lsb_val_d;
      dest_q     <= dest_d;
      val_q      <= val_d;
      pc_q       <= pc_d;
      src_q      <= src_d;
`ifndef RESULT_BUS_ARB_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign dest_to_bus    = dest_q;
  assign value_to_bus   = val_q;
  assign next_pc_to_bus = pc_q;
  assign src_to_bus     = src_q;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed, table-driven bench for result_bus_arbiter. Each record is one
// clock cycle: inputs, the expected ready outputs during that cycle and the
// expected bus registers after its rising edge. Honors
// RESULT_BUS_ARB_FIXED_PRIO_EN for the contention rows.
module tb_result_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, reset_from_rob_bus;
  logic [4:0]  dest_from_rss, dest_from_lsb;
  logic [31:0] value_from_rss, next_pc_from_rss, value_from_lsb;
  logic        ready_to_rss, ready_to_lsb;
  logic [4:0]  dest_to_bus;
  logic [31:0] value_to_bus, next_pc_to_bus;
  logic        src_to_bus;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  result_bus_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .reset_from_rob_bus(reset_from_rob_bus),
    .dest_from_rss(dest_from_rss), .value_from_rss(value_from_rss),
    .next_pc_from_rss(next_pc_from_rss), .ready_to_rss(ready_to_rss),
    .dest_from_lsb(dest_from_lsb), .value_from_lsb(value_from_lsb),
    .ready_to_lsb(ready_to_lsb), .dest_to_bus(dest_to_bus),
    .value_to_bus(value_to_bus), .next_pc_to_bus(next_pc_to_bus),
    .src_to_bus(src_to_bus)
  );

  typedef struct {
    bit          rst, rdy, fl;
    logic [4:0]  rd;
    logic [31:0] rv, rp;
    logic [4:0]  ld;
    logic [31:0] lv;
    bit          err, erl;
    logic [4:0]  ed;
    logic [31:0] ev, ep;
    bit          es;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit y, bit f, logic [4:0] rd, logic [31:0] rv,
                              logic [31:0] rp, logic [4:0] ld, logic [31:0] lv,
                              bit err, bit erl, logic [4:0] ed, logic [31:0] ev,
                              logic [31:0] ep, bit es);
    vec_t v;
    v.rst = r; v.rdy = y; v.fl = f; v.rd = rd; v.rv = rv; v.rp = rp;
    v.ld = ld; v.lv = lv; v.err = err; v.erl = erl;
    v.ed = ed; v.ev = ev; v.ep = ep; v.es = es;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; rdy = v.rdy; reset_from_rob_bus = v.fl;
    dest_from_rss = v.rd; value_from_rss = v.rv; next_pc_from_rss = v.rp;
    dest_from_lsb = v.ld; value_from_lsb = v.lv;
    #1;
    check("ready_to_rss", idx, 32'(ready_to_rss), 32'(v.err));
    check("ready_to_lsb", idx, 32'(ready_to_lsb), 32'(v.erl));
    @(posedge clk);
    #1;
    check("dest_to_bus", idx, 32'(dest_to_bus), 32'(v.ed));
    check("value_to_bus", idx, value_to_bus, v.ev);
    check("next_pc_to_bus", idx, next_pc_to_bus, v.ep);
    check("src_to_bus", idx, 32'(src_to_bus), 32'(v.es));
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; reset_from_rob_bus = 1'b0;
    dest_from_rss = '0; value_from_rss = '0; next_pc_from_rss = '0;
    dest_from_lsb = '0; value_from_lsb = '0;

    // reset, including reset while rdy is low
    tbl.push_back(mk(1,1,0, 0,0,0, 0,0, 0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0));
    // single rss request, latency 2, one-cycle broadcast
    tbl.push_back(mk(0,1,0, 3,'h11,'h104, 0,0, 1,1, 0,0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 1,1, 3,'h11,'h104,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 1,1, 0,0,0,0));
    // both requesters presenting for 4 cycles
    tbl.push_back(mk(0,1,0, 2,'h22,'h200, 5,'h55, 1,1, 0,0,0,0));
`ifdef RESULT_BUS_ARB_FIXED_PRIO_EN
    tbl.push_back(mk(0,1,0, 2,'h22,'h200, 5,'h55, 0,1, 5,'h55,0,1));
    tbl.push_back(mk(0,1,0, 2,'h22,'h200, 5,'h55, 0,1, 5,'h55,0,1));
    tbl.push_back(mk(0,1,0, 2,'h22,'h200, 5,'h55, 0,1, 5,'h55,0,1));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 0,1, 5,'h55,0,1));
`else
    tbl.push_back(mk(0,1,0, 2,'h22,'h200, 5,'h55, 1,0, 2,'h22,'h200,0));
    tbl.push_back(mk(0,1,0, 2,'h22,'h200, 5,'h55, 0,1, 5,'h55,0,1));
    tbl.push_back(mk(0,1,0, 2,'h22,'h200, 5,'h55, 1,0, 2,'h22,'h200,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 0,1, 5,'h55,0,1));
`endif
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 1,1, 2,'h22,'h200,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 1,1, 0,0,0,0));
    // lsb accepted, then rdy low for 3 cycles
    tbl.push_back(mk(0,1,0, 0,0,0, 7,'h77, 1,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 1,1, 7,'h77,0,1));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 1,1, 0,0,0,0));
    // a visible broadcast is held while rdy is low
    tbl.push_back(mk(0,1,0, 6,'h66,'h600, 0,0, 1,1, 0,0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 1,1, 6,'h66,'h600,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0, 6,'h66,'h600,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0, 6,'h66,'h600,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 1,1, 0,0,0,0));
    // flush with both slots busy and a new rss id 4 (rdy low)
    tbl.push_back(mk(0,1,0, 'hA,'hAA,'hA00, 'hB,'hBB, 1,1, 0,0,0,0));
`ifdef RESULT_BUS_ARB_FIXED_PRIO_EN
    tbl.push_back(mk(0,1,0, 'hC,'hCC,'hC00, 0,0, 0,1, 'hB,'hBB,0,1));
`else
    tbl.push_back(mk(0,1,0, 'hC,'hCC,'hC00, 0,0, 1,0, 'hA,'hAA,'hA00,0));
`endif
    tbl.push_back(mk(0,0,1, 4,'h44,'h400, 0,0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 1,1, 0,0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 1,1, 0,0,0,0));
    // pointer must be back at rss-first after the flush
    tbl.push_back(mk(0,1,0, 'hD,'hDD,'hD00, 'hE,'hEE, 1,1, 0,0,0,0));
`ifdef RESULT_BUS_ARB_FIXED_PRIO_EN
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 0,1, 'hE,'hEE,0,1));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 1,1, 'hD,'hDD,'hD00,0));
`else
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 1,0, 'hD,'hDD,'hD00,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 1,1, 'hE,'hEE,0,1));
`endif
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 1,1, 0,0,0,0));
    // rst mid-stream with both slots full
    tbl.push_back(mk(0,1,0, 'h10,'h1010,'h1000, 'h11,'h1111, 1,1, 0,0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 'h12,'h1212, 0,1, 'h11,'h1111,0,1));
    tbl.push_back(mk(1,1,0, 0,0,0, 0,0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0, 'h13,'h1313,'h1300, 0,0, 1,1, 0,0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 1,1, 'h13,'h1313,'h1300,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 1,1, 0,0,0,0));

    foreach (tbl[i]) apply(tbl[i], i);

    // flush with rdy high wipes a visible broadcast and a same-cycle lsb request
    apply(mk(0,1,0, 'h14,'h1414,'h1400, 0,0, 1,1, 0,0,0,0), 100);
    apply(mk(0,1,0, 0,0,0, 0,0, 1,1, 'h14,'h1414,'h1400,0), 101);
    apply(mk(0,1,1, 0,0,0, 'h15,'h1515, 0,0, 0,0,0,0), 102);
    apply(mk(0,1,0, 0,0,0, 0,0, 1,1, 0,0,0,0), 103);
    apply(mk(0,1,0, 0,0,0, 0,0, 1,1, 0,0,0,0), 104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
